// File: rtl/trace_pkg.sv
// Shared types and default sizing for the instruction-trace capture buffer.
package trace_pkg;

    localparam int unsigned TRACE_WIDTH      = 32;
    localparam int unsigned TRACE_INST_SIZE  = 32;
    localparam int unsigned TRACE_DEPTH_LOG2 = 4;
    localparam int unsigned TRACE_DEPTH      = 1 << TRACE_DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_WIDTH-1:0]     pc;
        logic [TRACE_INST_SIZE-1:0] instr;
    } trace_entry_t;

endpackage

// File: rtl/trace_capture_unit_mem.sv
// Trace storage: one synchronous write port, one asynchronous read port, no reset.
module trace_mem #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/trace_capture_unit.sv
// Instruction-trace capture: circular store of retired {pc, instr}, PC trigger with
// post-trigger window, then oldest-first drain over a valid/ready port.
module trace_capture_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned INST_SIZE  = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trace_valid,
    input  logic [WIDTH-1:0]      trace_pc,
    input  logic [INST_SIZE-1:0]  trace_instr,
    input  logic                  trig_en,
    input  logic [WIDTH-1:0]      trig_pc,
    input  logic [DEPTH_LOG2:0]   post_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_pc,
    output logic [INST_SIZE-1:0]  rd_instr,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  done,
    output logic [1:0]            state_o
);
    import trace_pkg::*;

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned ENTRY_W = WIDTH + INST_SIZE;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;

    trace_state_e          state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      post_rem_q, post_rem_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  wr_en_c;
    logic                  trig_hit_c;
    logic                  pop_c;
    logic [CNT_W-1:0]      eff_win_c;
    logic [ENTRY_W-1:0]    rd_data_c;

    trace_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we      (wr_en_c),
        .waddr   (wr_ptr_q),
        .wdata   ({trace_pc, trace_instr}),
        .raddr   (rd_ptr_q),
        .rdata_c (rd_data_c)
    );

    // Post-trigger window clamped to 1..DEPTH entries, trigger entry included.
    always_comb begin
        eff_win_c = post_count;
        if (post_count == '0) begin
            eff_win_c = CNT_W'(1);
        end else if (post_count > CNT_W'(DEPTH)) begin
            eff_win_c = CNT_W'(DEPTH);
        end
    end

    assign trig_hit_c = !trig_en || (trace_pc == trig_pc);
    assign pop_c      = rd_valid_q && rd_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_rem_d = post_rem_q;
        overflow_d = overflow_q;
        wr_en_c    = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_rem_d = '0;
            overflow_d = 1'b0;
        end else if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ARMED, POST: begin
                    if (trace_valid) begin
                        wr_en_c  = 1'b1;
                        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                        if (count_q < CNT_W'(DEPTH)) begin
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (state_q == ARMED) begin
                            if (trig_hit_c) begin
                                post_rem_d = eff_win_c - CNT_W'(1);
                                state_d    = (eff_win_c == CNT_W'(1)) ? DONE : POST;
                            end
                        end else begin
                            post_rem_d = post_rem_q - CNT_W'(1);
                            if (post_rem_q == CNT_W'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (pop_c) begin
                        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
                        count_d  = count_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase

            // Oldest surviving entry sits count entries behind the write pointer.
            if ((state_d == DONE) && (state_q != DONE)) begin
                rd_ptr_d = wr_ptr_d - count_d[DEPTH_LOG2-1:0];
            end
        end

        done_d     = (state_d == DONE);
        rd_valid_d = (state_d == DONE) && (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_rem_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_rem_q <= post_rem_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_pc    = rd_valid_q ? rd_data_c[ENTRY_W-1 -: WIDTH] : '0;
    assign rd_instr = rd_valid_q ? rd_data_c[INST_SIZE-1:0] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
Synthesizable instruction-trace capture buffer for the single-cycle core. It records retired {PC, instruction} pairs into a DEPTH-entry circular store and stops on a programmable PC trigger plus a post-trigger window. After capture it drains oldest-first over a valid/ready port to the debug or UART path. It replaces per-cycle simulation printing with on-chip trace that also works in hardware.

Parameters:
WIDTH, 32, PC width
INST_SIZE, 32, instruction width
DEPTH_LOG2, 4, log2 of buffer entries (DEPTH = 16)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
arm  in  1  start or restart capture; clears buffer
abort  in  1  return to IDLE and clear buffer
trace_valid  in  1  one instruction retired this cycle
trace_pc  in  WIDTH  PC of retired instruction
trace_instr  in  INST_SIZE  retired instruction word
trig_en  in  1  1 = trigger on PC match; 0 = trigger on first captured entry
trig_pc  in  WIDTH  trigger PC
post_count  in  DEPTH_LOG2+1  entries captured from the trigger entry onward
rd_valid  out  1  entry available (DONE and count != 0)
rd_ready  in  1  consumer accepts entry
rd_pc  out  WIDTH  oldest entry PC; 0 when rd_valid=0
rd_instr  out  INST_SIZE  oldest entry instruction; 0 when rd_valid=0
count  out  DEPTH_LOG2+1  valid entries held
overflow  out  1  at least one pre-trigger entry was overwritten
done  out  1  state == DONE
state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3

Behaviour:
- Reset (rst=0, async): state IDLE, wr_ptr/rd_ptr/count/post_rem 0, overflow 0, done 0, rd_valid 0, rd_pc/rd_instr 0. Memory contents are not reset.
- Priority every cycle: abort > arm > normal operation.
- abort, any state: next state IDLE; count, overflow and pointers cleared.
- arm, any state: next state ARMED; wr_ptr, count and overflow cleared. A trace_valid in the same cycle is NOT captured.
- IDLE: trace_valid ignored.
- ARMED, trace_valid=1:
  - Write {pc, instr} at wr_ptr; wr_ptr++ mod DEPTH (wraps).
  - If count < DEPTH, count++; otherwise count holds and overflow is set (oldest entry overwritten).
  - Trigger is true when trig_en=0, or when trace_pc == trig_pc. The triggering entry is itself captured.
  - Effective window eff = post_count clamped to 1..DEPTH (0 is treated as 1; values > DEPTH become DEPTH).
  - On trigger: post_rem = eff - 1. Next state DONE if post_rem == 0, otherwise POST.
- POST, trace_valid=1: write as in ARMED; post_rem--. Enter DONE on the edge where post_rem reaches 0. Post-trigger entries may overwrite pre-trigger entries; overflow is then set.
- DONE:
  - No writes; trace_valid ignored.
  - rd_ptr = wr_ptr - count (mod DEPTH), computed on DONE entry.
  - rd_valid = (count != 0). rd_pc/rd_instr are a combinational read of mem[rd_ptr].
  - On rd_valid && rd_ready: rd_ptr++, count--.
  - Data is held stable while rd_valid && !rd_ready.
  - After the last pop: rd_valid=0 and the unit stays in DONE until arm or abort.
- All state, count, overflow and done updates occur on the clk edge that samples the qualifying input. done and state_o are registered and visible in the cycle after that edge.
- Pointer arithmetic is modulo DEPTH. count is DEPTH_LOG2+1 bits so the value DEPTH is representable.

Decomposition:
- Package trace_pkg: state enum trace_state_e (IDLE, ARMED, POST, DONE); packed struct trace_entry_t {pc, instr}; localparam DEPTH = 1 << DEPTH_LOG2.
- Sub-module trace_mem: DEPTH x (WIDTH+INST_SIZE), one synchronous write port, one asynchronous read port, no reset.
- The FSM, pointers, counters and read handshake live in trace_capture_unit.

Test Plan:
1. Set trig_en=0, post_count=3, arm. Retire PCs 0x00, 0x04, 0x08 -> done=1 the cycle after the third edge, count=3, overflow=0. With rd_ready=1, readout is 0x00, 0x04, 0x08, then rd_valid=0.
2. Set trig_en=1, trig_pc=0x40, post_count=4. Retire PCs 0x00..0x5C step 4 -> DONE after PC 0x4C, count=16, overflow=1. Readout is 0x10..0x4C in order; later retires are not captured.
3. Backpressure: in DONE with count=5, hold rd_ready=0 for 3 cycles -> rd_pc stable and count=5. Then toggle rd_ready 1,0,1 -> exactly 2 entries popped, count=3.
4. Drive post_count=0 with trig_en=0 -> DONE after 1 entry, count=1. Drive post_count=20 -> DONE after 16 entries, count=16, overflow=0.
5. Assert arm and abort in the same cycle during POST -> state IDLE, count=0. Assert arm in DONE mid-readout -> next cycle state ARMED, count=0, rd_valid=0. Assert arm with trace_valid=1 in the same cycle -> that entry is not counted.
6. Pull rst low asynchronously mid-POST, between clock edges -> state_o=0, count=0, done=0, rd_valid=0, rd_pc=0 immediately. After release, behaviour resumes from IDLE and requires a new arm.
